iob_2p_asym_fifo_ctrl: RTL

IOB_2P_ASYM_FIFO_CTRL -- requirements
Module: iob_2p_asym_fifo_ctrl

---
 rtl/iob_2p_asym_fifo_ctrl_pkg.sv | 21 ++
 rtl/iob_asym_fifo_lvl.sv | 36 +++
 rtl/iob_2p_asym_fifo_ctrl.sv | 85 ++++++++
 3 files changed

// File: rtl/iob_2p_asym_fifo_ctrl_pkg.sv
// Shared width/size derivations for the asymmetric two-port FIFO controller.
// Fill level is counted in units of the narrower of the two data widths.
package iob_2p_asym_fifo_ctrl_pkg;

    function automatic int calc_min_w(input int w_data_w, input int r_data_w);
        return (w_data_w < r_data_w) ? w_data_w : r_data_w;
    endfunction

    function automatic int calc_inc(input int data_w, input int w_data_w, input int r_data_w);
        return data_w / calc_min_w(w_data_w, r_data_w);
    endfunction

    function automatic int calc_max_addr_w(input int w_addr_w, input int r_addr_w);
        return (w_addr_w > r_addr_w) ? w_addr_w : r_addr_w;
    endfunction

    function automatic int calc_cap(input int w_addr_w, input int r_addr_w);
        return 1 << calc_max_addr_w(w_addr_w, r_addr_w);
    endfunction

endpackage

// File: rtl/iob_asym_fifo_lvl.sv
// Fill-level register and full/empty flags for the asymmetric FIFO.
// Level moves by W_INC per accepted write and R_INC per accepted read.
module iob_asym_fifo_lvl #(
    parameter int LVL_W = 8,
    parameter int W_INC = 2,
    parameter int R_INC = 1,
    parameter int CAP   = 128
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             w_acc,
    input  logic             r_acc,
    output logic [LVL_W-1:0] level,
    output logic             full,
    output logic             empty
);

    logic [LVL_W-1:0] level_next;

    always_comb begin
        // NOTE: default assigned first so every path writes level_next; no latch.
        level_next = level;
        if (w_acc) level_next = level_next + LVL_W'(W_INC);
        if (r_acc) level_next = level_next - LVL_W'(R_INC);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking for state so all registers update from pre-edge values.
        if (rst) level <= '0;
        else     level <= level_next;
    end

    assign full  = (level > LVL_W'(CAP - W_INC));
    assign empty = (level < LVL_W'(R_INC));

endmodule

// File: rtl/iob_2p_asym_fifo_ctrl.sv
// Controller for a FIFO built on an external asymmetric two-port RAM:
// pointers, accept logic and the one-cycle read-valid pipeline.
module iob_2p_asym_fifo_ctrl
    import iob_2p_asym_fifo_ctrl_pkg::*;
#(
    parameter int W_DATA_W = 16,
    parameter int R_DATA_W = 8,
    parameter int W_ADDR_W = 6,
    parameter int R_ADDR_W = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                w_en_i,
    input  logic [W_DATA_W-1:0] w_data_i,
    output logic                w_full_o,
    input  logic                r_en_i,
    output logic [R_DATA_W-1:0] r_data_o,
    output logic                r_valid_o,
    output logic                r_empty_o,
    output logic [((W_ADDR_W > R_ADDR_W) ? W_ADDR_W : R_ADDR_W):0] level_o,
    output logic                mem_w_en_o,
    output logic [W_ADDR_W-1:0] mem_w_addr_o,
    output logic [W_DATA_W-1:0] mem_w_data_o,
    output logic                mem_r_en_o,
    output logic [R_ADDR_W-1:0] mem_r_addr_o,
    input  logic [R_DATA_W-1:0] mem_r_data_i
);

    localparam int W_INC = calc_inc(W_DATA_W, W_DATA_W, R_DATA_W);
    localparam int R_INC = calc_inc(R_DATA_W, W_DATA_W, R_DATA_W);
    localparam int CAP   = calc_cap(W_ADDR_W, R_ADDR_W);
    localparam int LVL_W = calc_max_addr_w(W_ADDR_W, R_ADDR_W) + 1;

    logic [W_ADDR_W-1:0] w_ptr;
    logic [R_ADDR_W-1:0] r_ptr;
    logic                r_valid_q;
    logic                w_acc;
    logic                r_acc;
    logic                full;
    logic                empty;

    // Reset blocks both memory ports; the RAM itself keeps its contents.
    assign w_acc = w_en_i & ~full & ~rst;
    assign r_acc = r_en_i & ~empty & ~rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            w_ptr     <= '0;
            r_ptr     <= '0;
            r_valid_q <= 1'b0;
        end else begin
            if (w_acc) w_ptr <= w_ptr + W_ADDR_W'(1);
            if (r_acc) r_ptr <= r_ptr + R_ADDR_W'(1);
            r_valid_q <= r_acc;
        end
    end

    iob_asym_fifo_lvl #(
        .LVL_W (LVL_W),
        .W_INC (W_INC),
        .R_INC (R_INC),
        .CAP   (CAP)
    ) u_lvl (
        .clk   (clk),
        .rst   (rst),
        .w_acc (w_acc),
        .r_acc (r_acc),
        .level (level_o),
        .full  (full),
        .empty (empty)
    );

    assign w_full_o     = full;
    assign r_empty_o    = empty;
    assign mem_w_en_o   = w_acc;
    assign mem_w_addr_o = w_ptr;
    assign mem_w_data_o = w_data_i;
    assign mem_r_en_o   = r_acc;
    assign mem_r_addr_o = r_ptr;

    // A read accepted just before reset is dropped rather than reported.
    assign r_valid_o = r_valid_q & ~rst;
    assign r_data_o  = mem_r_data_i;

endmodule
